// File: rtl/phoenix_memory_arbiter_if.sv
// Request/response bundle between the fetch unit, the LSU, the arbiter and the shared memory.
// slave = arbiter side; master = requesters plus memory model.
interface phoenix_memory_arbiter_if #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
);
  localparam int MW = DATA_WIDTH / 8;

  logic                     fetch_req;
  logic [ADDRESS_WIDTH-1:0] fetch_address;
  logic                     fetch_gnt;
  logic                     fetch_valid;
  logic [DATA_WIDTH-1:0]    fetch_data;

  logic                     lsu_req;
  logic                     lsu_write;
  logic [ADDRESS_WIDTH-1:0] lsu_address;
  logic [DATA_WIDTH-1:0]    lsu_wdata;
  logic [MW-1:0]            lsu_mask;
  logic                     lsu_gnt;
  logic                     lsu_valid;
  logic [DATA_WIDTH-1:0]    lsu_rdata;

  logic                     mem_enable;
  logic                     mem_write;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [MW-1:0]            mem_mask;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  logic                     busy;

  modport slave (
    input  fetch_req, fetch_address,
    input  lsu_req, lsu_write, lsu_address, lsu_wdata, lsu_mask,
    input  mem_rdata,
    output fetch_gnt, fetch_valid, fetch_data,
    output lsu_gnt, lsu_valid, lsu_rdata,
    output mem_enable, mem_write, mem_address, mem_wdata, mem_mask,
    output busy
  );

  modport master (
    output fetch_req, fetch_address,
    output lsu_req, lsu_write, lsu_address, lsu_wdata, lsu_mask,
    output mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_data,
    input  lsu_gnt, lsu_valid, lsu_rdata,
    input  mem_enable, mem_write, mem_address, mem_wdata, mem_mask,
    input  busy
  );
endinterface

// File: rtl/phoenix_memory_arbiter.sv
// Fetch/LSU arbiter for one fixed-latency single-ported memory.
// LSU has priority; a saturating starve counter forces a fetch grant after STARVE_LIMIT LSU wins.
module phoenix_memory_arbiter #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input logic CLK,
  input logic reset,
  phoenix_memory_arbiter_if.slave bus
);
  localparam int MW = DATA_WIDTH / 8;
  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  typedef struct packed {
    logic                     owner_lsu;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [MW-1:0]            mask;
  } req_t;

  state_t         state;
  req_t           req_q;
  req_t           req_n;
  logic [LW-1:0]  lat;
  logic [SW-1:0]  starve;
  logic           pick_fetch;
  logic           pick_lsu;

  always_comb begin
    pick_fetch = bus.fetch_req && (!bus.lsu_req || starve == SW'(STARVE_LIMIT));
    pick_lsu   = bus.lsu_req && !pick_fetch;
    req_n      = '0;
    if (pick_lsu) begin
      req_n.owner_lsu = 1'b1;
      req_n.write     = bus.lsu_write;
      req_n.address   = bus.lsu_address;
      // Loads never drive write data or byte enables onto the memory.
      req_n.wdata     = bus.lsu_write ? bus.lsu_wdata : '0;
      req_n.mask      = bus.lsu_write ? bus.lsu_mask  : '0;
    end else if (pick_fetch) begin
      req_n.address   = bus.fetch_address;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      req_q           <= '0;
      lat             <= '0;
      starve          <= '0;
      bus.fetch_gnt   <= 1'b0;
      bus.fetch_valid <= 1'b0;
      bus.fetch_data  <= '0;
      bus.lsu_gnt     <= 1'b0;
      bus.lsu_valid   <= 1'b0;
      bus.lsu_rdata   <= '0;
      bus.mem_enable  <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_mask    <= '0;
      bus.busy        <= 1'b0;
    end else begin
      case (state)
        IDLE, RESPOND: begin
          bus.fetch_valid <= 1'b0;
          bus.lsu_valid   <= 1'b0;
          bus.fetch_data  <= '0;
          bus.lsu_rdata   <= '0;
          if (!bus.fetch_req || pick_fetch)
            starve <= '0;
          else if (pick_lsu && starve != SW'(STARVE_LIMIT))
            starve <= starve + 1'b1;
          if (pick_fetch || pick_lsu) begin
            state           <= ACCESS;
            req_q           <= req_n;
            lat             <= LW'(MEM_LATENCY - 1);
            bus.fetch_gnt   <= pick_fetch;
            bus.lsu_gnt     <= pick_lsu;
            bus.mem_enable  <= 1'b1;
            bus.mem_write   <= req_n.write;
            bus.mem_address <= req_n.address;
            bus.mem_wdata   <= req_n.wdata;
            bus.mem_mask    <= req_n.mask;
            bus.busy        <= 1'b1;
          end else begin
            state           <= IDLE;
            bus.fetch_gnt   <= 1'b0;
            bus.lsu_gnt     <= 1'b0;
            bus.mem_enable  <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_mask    <= '0;
            bus.busy        <= 1'b0;
          end
        end
        ACCESS: begin
          bus.fetch_gnt <= 1'b0;
          bus.lsu_gnt   <= 1'b0;
          if (lat == '0) begin
            // Memory data is valid in the last enable cycle; capture it straight into the response.
            state           <= RESPOND;
            bus.mem_enable  <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_mask    <= '0;
            bus.busy        <= 1'b0;
            if (req_q.owner_lsu) begin
              bus.lsu_valid <= 1'b1;
              bus.lsu_rdata <= req_q.write ? '0 : bus.mem_rdata;
            end else begin
              bus.fetch_valid <= 1'b1;
              bus.fetch_data  <= bus.mem_rdata;
            end
          end else begin
            lat <= lat - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phoenix_memory_arbiter.sv
// Directed bench: single fetch, store, load, contention, starvation order, mid-access reset, L=1 throughput.
module tb_phoenix_memory_arbiter;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  phoenix_memory_arbiter_if #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) bus  ();
  phoenix_memory_arbiter_if #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) bus1 ();

  phoenix_memory_arbiter #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4))
    dut (.CLK(CLK), .reset(reset), .bus(bus));

  phoenix_memory_arbiter #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4))
    dut1 (.CLK(CLK), .reset(reset), .bus(bus1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [9:0] order;
    logic [5:0] g;
    logic [5:0] v;
    int ng;
    int both;
    int nv;

    bus.fetch_req = 0; bus.fetch_address = '0;
    bus.lsu_req = 0; bus.lsu_write = 0; bus.lsu_address = '0;
    bus.lsu_wdata = '0; bus.lsu_mask = '0; bus.mem_rdata = '0;
    bus1.fetch_req = 0; bus1.fetch_address = '0;
    bus1.lsu_req = 0; bus1.lsu_write = 0; bus1.lsu_address = '0;
    bus1.lsu_wdata = '0; bus1.lsu_mask = '0; bus1.mem_rdata = '0;
    order = '0; g = '0; v = '0;

    // reset state
    tick(); tick();
    chk("rst_outputs", {bus.fetch_gnt, bus.fetch_valid, bus.lsu_gnt, bus.lsu_valid,
                        bus.mem_enable, bus.mem_write, bus.busy}, 7'b0);
    chk("rst_mem_addr", bus.mem_address, 12'h000);
    reset = 1;
    tick();
    chk("idle_busy", bus.busy, 1'b0);

    // single fetch, L=2
    bus.fetch_req = 1; bus.fetch_address = 12'h010; bus.mem_rdata = 32'h0000_0513;
    tick();
    chk("f1_gnt", bus.fetch_gnt, 1'b1);
    chk("f1_en_c1", bus.mem_enable, 1'b1);
    chk("f1_addr", bus.mem_address, 12'h010);
    chk("f1_wr", bus.mem_write, 1'b0);
    chk("f1_busy", bus.busy, 1'b1);
    bus.fetch_req = 0; bus.fetch_address = 12'h3FC;
    tick();
    chk("f1_gnt_c2", bus.fetch_gnt, 1'b0);
    chk("f1_en_c2", bus.mem_enable, 1'b1);
    chk("f1_addr_c2", bus.mem_address, 12'h010);
    chk("f1_vld_c2", bus.fetch_valid, 1'b0);
    tick();
    chk("f1_vld_c3", bus.fetch_valid, 1'b1);
    chk("f1_data", bus.fetch_data, 32'h0000_0513);
    chk("f1_en_c3", bus.mem_enable, 1'b0);
    chk("f1_lsu_vld", bus.lsu_valid, 1'b0);
    tick();
    chk("f1_vld_c4", bus.fetch_valid, 1'b0);

    // LSU store
    bus.lsu_req = 1; bus.lsu_write = 1; bus.lsu_address = 12'h100;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_mask = 4'hF; bus.mem_rdata = 32'h1234_5678;
    tick();
    chk("st_gnt", bus.lsu_gnt, 1'b1);
    chk("st_fgnt", bus.fetch_gnt, 1'b0);
    chk("st_wr_c1", {bus.mem_enable, bus.mem_write}, 2'b11);
    chk("st_addr", bus.mem_address, 12'h100);
    chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("st_mask", bus.mem_mask, 4'hF);
    bus.lsu_req = 0; bus.lsu_wdata = 32'h0; bus.lsu_mask = 4'h0; bus.lsu_address = 12'h0;
    tick();
    chk("st_wr_c2", {bus.mem_enable, bus.mem_write}, 2'b11);
    chk("st_wdata_c2", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("st_vld", bus.lsu_valid, 1'b1);
    chk("st_rdata", bus.lsu_rdata, 32'h0);
    chk("st_wr_c3", bus.mem_write, 1'b0);
    tick();

    // LSU load: mask/write suppressed on the memory side
    bus.lsu_req = 1; bus.lsu_write = 0; bus.lsu_address = 12'h044;
    bus.lsu_mask = 4'hF; bus.lsu_wdata = 32'h5555_5555; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("ld_gnt", bus.lsu_gnt, 1'b1);
    chk("ld_wr_mask", {bus.mem_write, bus.mem_mask}, 5'b0);
    bus.lsu_req = 0;
    tick(); tick();
    chk("ld_vld", bus.lsu_valid, 1'b1);
    chk("ld_rdata", bus.lsu_rdata, 32'hCAFE_F00D);
    tick();

    // simultaneous requests: LSU first, fetch follows
    bus.fetch_req = 1; bus.fetch_address = 12'h020;
    bus.lsu_req = 1; bus.lsu_write = 0; bus.lsu_address = 12'h200; bus.mem_rdata = 32'h0000_00AA;
    tick();
    chk("sim_c1", {bus.lsu_gnt, bus.fetch_gnt}, 2'b10);
    chk("sim_addr", bus.mem_address, 12'h200);
    bus.lsu_req = 0;
    tick(); tick();
    chk("sim_c3", {bus.lsu_valid, bus.fetch_valid}, 2'b10);
    chk("sim_c3_gnt", bus.fetch_gnt, 1'b0);
    tick();
    chk("sim_c4", {bus.lsu_gnt, bus.fetch_gnt}, 2'b01);
    chk("sim_faddr", bus.mem_address, 12'h020);
    bus.fetch_req = 0;
    tick();
    chk("sim_c5", bus.fetch_valid, 1'b0);
    tick();
    chk("sim_c6", {bus.lsu_valid, bus.fetch_valid}, 2'b01);
    tick(); tick();

    // starvation: both held high
    ng = 0; both = 0;
    bus.fetch_req = 1; bus.lsu_req = 1; bus.lsu_write = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      tick();
      if (bus.lsu_gnt && bus.fetch_gnt) both++;
      if (bus.fetch_gnt) begin order[ng] = 1'b1; ng++; end
      else if (bus.lsu_gnt) begin order[ng] = 1'b0; ng++; end
    end
    bus.fetch_req = 0; bus.lsu_req = 0;
    chk("starve_ngrants", ng, 10);
    chk("starve_order", order, 10'b10_0001_0000);
    chk("gnt_exclusive", both, 0);
    for (int c = 0; c < 5; c++) tick();

    // reset in the middle of an access
    bus.fetch_req = 1; bus.fetch_address = 12'h030; bus.mem_rdata = 32'h0BAD_0BAD;
    tick();
    chk("ra_gnt", bus.fetch_gnt, 1'b1);
    bus.fetch_req = 0;
    tick();
    chk("ra_en_c2", bus.mem_enable, 1'b1);
    reset = 0;
    #1;
    chk("ra_abort", {bus.mem_enable, bus.busy, bus.fetch_gnt, bus.fetch_valid}, 4'b0);
    chk("ra_addr", bus.mem_address, 12'h000);
    tick(); tick();
    reset = 1;
    nv = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.fetch_valid || bus.lsu_valid || bus.mem_enable) nv++;
    end
    chk("ra_no_valid", nv, 0);
    bus.lsu_req = 1; bus.lsu_write = 0; bus.lsu_address = 12'h048; bus.mem_rdata = 32'h0000_BEEF;
    tick();
    chk("ra_new_gnt", bus.lsu_gnt, 1'b1);
    bus.lsu_req = 0;
    tick();
    chk("ra_new_c2", bus.lsu_valid, 1'b0);
    tick();
    chk("ra_new_vld", bus.lsu_valid, 1'b1);
    chk("ra_new_data", bus.lsu_rdata, 32'h0000_BEEF);

    // MEM_LATENCY=1 back-to-back fetches
    bus1.fetch_req = 1; bus1.fetch_address = 12'h004; bus1.mem_rdata = 32'h0000_0013;
    for (int c = 0; c < 6; c++) begin
      tick();
      g[c] = bus1.fetch_gnt;
      v[c] = bus1.fetch_valid;
      if (c == 1) chk("l1_data", bus1.fetch_data, 32'h0000_0013);
    end
    bus1.fetch_req = 0;
    chk("l1_gnt_pattern", g, 6'b01_0101);
    chk("l1_vld_pattern", v, 6'b10_1010);
    tick(); tick();
    chk("l1_idle", {bus1.busy, bus1.mem_enable}, 2'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
